// File: rtl/snake_pkg.sv
// snake_pkg: shared phase encoding and constants for the snake score tracker
package snake_pkg;
  typedef enum logic [1:0] {
    PH_IDLE = 2'd0,
    PH_PLAY = 2'd1,
    PH_OVER = 2'd2
  } phase_t;
  localparam int FOOD_W = 2;
  localparam int LEVEL_MAX = 15;
endpackage

// File: rtl/snake_player_counter.sv
// snake_player_counter: saturating score and length registers for one snake
module snake_player_counter
  import snake_pkg::*;
#(
  parameter int W = 16,
  parameter int INIT_LEN = 3,
  parameter int MAX_LEN = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              inc_en,
  input  logic [FOOD_W-1:0] value,
  output logic [W-1:0]      score,
  output logic [W-1:0]      length
);
  logic [FOOD_W-1:0] pts;
  logic [W:0] sum;
  // zero-valued food still counts as one point
  assign pts = (value == '0) ? FOOD_W'(1) : value;
  assign sum = {1'b0, score} + {{(W + 1 - FOOD_W){1'b0}}, pts};
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      score  <= '0;
      length <= W'(INIT_LEN);
    end else if (inc_en) begin
      score  <= sum[W] ? '1 : sum[W-1:0];
      length <= (length == W'(MAX_LEN)) ? length : length + W'(1);
    end
  end
endmodule

// File: rtl/snake_score_tracker.sv
// snake_score_tracker: multi-snake score/length, game phase, level and high score.
// SNAKE_SCORE_TRACKER_HISCORE_EN builds the session high-score register.
module snake_score_tracker
  import snake_pkg::*;
#(
  parameter int NUM_PLAYERS = 2,
  parameter int W = 16,
  parameter int INIT_LEN = 3,
  parameter int MAX_LEN = 64,
  parameter int LEVEL_STEP = 5
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [NUM_PLAYERS-1:0]     eaten,
  input  logic [2*NUM_PLAYERS-1:0]   food_value,
  input  logic [NUM_PLAYERS-1:0]     collide,
  output logic [W*NUM_PLAYERS-1:0]   score,
  output logic [W*NUM_PLAYERS-1:0]   length,
  output logic [3:0]                 level,
  output logic [1:0]                 phase,
  output logic                       game_over,
  output logic [W-1:0]               hi_score
);
  localparam int SW = $clog2(2 * LEVEL_STEP);
  phase_t state, state_n;
  logic allowed, clear, any_max, lvl_up;
  logic [SW-1:0] step, step_sum;
  assign allowed = (state == PH_PLAY) && !(|collide);
  assign clear = (state == PH_OVER) && start;
  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
    snake_player_counter #(.W(W), .INIT_LEN(INIT_LEN), .MAX_LEN(MAX_LEN)) u_cnt (
      .clk    (clk),
      .reset  (reset),
      .clear  (clear),
      .inc_en (eaten[p] && allowed),
      .value  (food_value[FOOD_W*p +: FOOD_W]),
      .score  (score[W*p +: W]),
      .length (length[W*p +: W])
    );
  end
  always_comb begin
    any_max = 1'b0;
    step_sum = step;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      any_max = any_max | (length[W*p +: W] == W'(MAX_LEN));
      step_sum = step_sum + SW'(eaten[p] && allowed);
    end
    lvl_up = step_sum >= SW'(LEVEL_STEP);
    state_n = (state == PH_IDLE) ? (start ? PH_PLAY : PH_IDLE) :
              (state == PH_PLAY) ? ((|collide || any_max) ? PH_OVER : PH_PLAY) :
              (start ? PH_PLAY : PH_OVER);
  end
  always_ff @(posedge clk) begin
    if (reset) state <= PH_IDLE;
    else state <= state_n;
  end
  // LEVEL_STEP >= NUM_PLAYERS keeps step_sum below 2*LEVEL_STEP, so one subtract suffices
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      step  <= '0;
      level <= '0;
    end else if (lvl_up) begin
      step  <= step_sum - SW'(LEVEL_STEP);
      level <= (level == 4'(LEVEL_MAX)) ? level : level + 4'd1;
    end else begin
      step  <= step_sum;
    end
  end
  assign phase = state;
  assign game_over = (state == PH_OVER);
`ifdef SNAKE_SCORE_TRACKER_HISCORE_EN
  logic [W-1:0] hi_q, hi_max;
  always_comb begin
    hi_max = hi_q;
    for (int p = 0; p < NUM_PLAYERS; p++)
      hi_max = (score[W*p +: W] > hi_max) ? score[W*p +: W] : hi_max;
  end
  always_ff @(posedge clk) begin
    if (reset) hi_q <= '0;
    else hi_q <= hi_max;
  end
  assign hi_score = hi_q;
`else
  assign hi_score = '0;
`endif
endmodule
